dmac_ch0_ctrl: RTL and testbench
================================

Name: dmac_ch0_ctrl

Overview:
- Channel-0 transfer sequencer for the DMAC.
- Reads the register bank's channel state (CHANNEL_enable, TS, BS, DMACINTR_mask, master src/dest addresses) and drives the AHB master port.
- Moves data in bursts through an internal word buffer: read burst from source, then write burst to destination.
- Pulses the register-bank control flags (address load/increment, TS decrement, burst/buffer clears, channel disable, interrupt set).

Parameters:
- BUF_DEPTH, 16, buffer depth in 32-bit words; also the maximum beats per burst.
- BUF_AW, 4, buffer index width; must equal log2(BUF_DEPTH).

Ports:
- r_HCLK  in  1  system clock, rising edge.
- r_HRESET  in  1  reset, asynchronous, active-high.
- CHANNEL_enable  in  1  channel enable from the register bank.
- TS  in  12  remaining transfer size in bytes (multiple of 4).
- BS  in  3  burst-size code.
- DMACINTR_mask  in  1  interrupt mask; 1 = suppress.
- src_addr  in  32  current master source address.
- dest_addr  in  32  current master destination address.
- m_HGRANT  in  1  bus grant.
- m_HREADY  in  1  transfer ready.
- m_HRDATA  in  32  read data.
- m_HBUSREQ  out  1  bus request.
- m_HTRANS  out  2  00 IDLE, 10 NONSEQ.
- m_HWRITE  out  1  write strobe.
- m_HADDR  out  32  address.
- m_HWDATA  out  32  write data.
- load_DMAC_C0_Addr  out  1  pulse.
- src_addr_inc  out  1  pulse.
- dest_addr_inc  out  1  pulse.
- TransferSize_dec_flag  out  1  pulse; register bank performs TS-4.
- buffer_idx_inc  out  1  pulse.
- buffer_zero_flag  out  1  pulse.
- src_burst_zero_flag  out  1  pulse.
- dest_burst_zero_flag  out  1  pulse.
- CHANNEL_dis_flag  out  1  pulse.
- set_DMACINTR_status  out  1  pulse.

Behaviour:
- Reset state: state=IDLE; all outputs 0 (m_HTRANS=00); beat counter and burst length 0. Buffer contents are don't-care.
- Clock and reset: one clock, r_HCLK; r_HRESET is asynchronous, active-high. Reset asserted mid-operation aborts immediately to IDLE with no flag pulses.
- Burst length: blen = BS 0→1, 1→4, 2→8, 3→16, else 1, then clipped to BUF_DEPTH. beats = min(blen, TS>>2), latched in LOAD and in NEXT.
- Transfer type: every beat is a non-pipelined single transfer. Address phase drives NONSEQ; data phase drives IDLE.

State machine:
- IDLE:
  - CHANNEL_enable=1 and TS!=0 → LOAD.
  - CHANNEL_enable=1 and TS==0 → DONE.
  - Otherwise stay.
- LOAD (1 cycle): pulse load_DMAC_C0_Addr, buffer_zero_flag, src_burst_zero_flag, dest_burst_zero_flag. Latch beats; cnt=0 → REQ.
- REQ: m_HBUSREQ=1. On m_HGRANT=1 → RD_ADDR. m_HBUSREQ stays 1 through RD_*/WR_* states.
- RD_ADDR: while m_HGRANT=1, drive m_HTRANS=NONSEQ, m_HWRITE=0, m_HADDR=src_addr. On m_HREADY=1 pulse src_addr_inc → RD_DATA. While grant is lost, drive IDLE and hold.
- RD_DATA: on m_HREADY=1, buf[cnt]<=m_HRDATA and pulse buffer_idx_inc.
  - If cnt==beats-1: cnt=0, pulse buffer_zero_flag, → WR_ADDR.
  - Else cnt++ → RD_ADDR.
- WR_ADDR: same as RD_ADDR but m_HWRITE=1, m_HADDR=dest_addr; pulse dest_addr_inc on ready → WR_DATA.
- WR_DATA: m_HWDATA=buf[cnt]. On m_HREADY=1 pulse TransferSize_dec_flag.
  - Last beat: pulse src_burst_zero_flag and dest_burst_zero_flag → NEXT.
  - Else cnt++ → WR_ADDR.
- NEXT (1 cycle): m_HBUSREQ=0.
  - CHANNEL_enable=0 → IDLE, no interrupt.
  - TS==0 → DONE.
  - Otherwise relatch beats; cnt=0 → REQ.
- DONE (1 cycle): pulse CHANNEL_dis_flag; pulse set_DMACINTR_status if DMACINTR_mask=0 → IDLE.

Boundary conditions:
- Channel disable mid-burst takes effect only at NEXT; the current burst always completes.
- TS not a multiple of 4: the low 2 bits are ignored.
- A TS of fewer than blen words shortens the final burst.
- m_HREADY=0 stretches any address or data phase indefinitely; flag pulses occur only on the ready cycle.
- All flag outputs are registered, single-cycle pulses.

Optional Feature:
- Macro: DMAC_ERR_ABORT_EN.
- Defined:
  - Adds input m_HRESP[1:0].
  - In RD_DATA or WR_DATA, m_HRESP=01 (ERROR) with m_HREADY=1 → ERR state: 1 cycle, m_HBUSREQ=0; pulse CHANNEL_dis_flag and set_DMACINTR_status regardless of mask → IDLE.
  - The erroring beat raises no buffer write, no TS decrement and no address increment pulse.
- Undefined: no m_HRESP port; responses are ignored and every ready data phase counts as success.

Test Plan:
- Reset: assert r_HRESET mid WR_DATA → m_HTRANS=00, m_HBUSREQ=0, all pulses 0, state IDLE; after release, no activity while CHANNEL_enable=0.
- Single burst: TS=16, BS=1, src=0x1000, dest=0x2000, grant and ready always 1 → 4 reads of 0x1000..0x100C, then 4 writes of the same data to 0x2000..0x200C; 4 TransferSize_dec_flag pulses; CHANNEL_dis_flag and set_DMACINTR_status each once.
- Partial final burst: TS=24, BS=1 → bursts of 4 then 2 words; REQ re-entered once; DMACINTR_mask=1 → set_DMACINTR_status never pulses.
- Wait states and grant loss: m_HREADY low 3 cycles on read beat 2; m_HGRANT low 2 cycles in WR_ADDR → phases stretched, m_HTRANS=00 while ungranted, data intact, no duplicate pulses.
- Disable and TS=0: CHANNEL_enable dropped mid-burst → burst completes, IDLE, no interrupt. Separately, enable with TS=0 → DONE directly, one CHANNEL_dis_flag, no bus request.
- DMAC_ERR_ABORT_EN: m_HRESP=01 on write beat 3 of a 4-beat burst → only 2 TransferSize_dec_flag pulses; set_DMACINTR_status pulses even with mask=1; ends in IDLE.

Source files
------------

// File: rtl/dmac_ch0_ctrl.sv
// dmac_ch0_ctrl: DMAC channel-0 transfer sequencer.
// Reads the channel state from the register bank and moves data in bursts.
// Each burst is a read burst from the source into a local word buffer,
// followed by a write burst from that buffer to the destination.
// Every bus beat is a single NONSEQ address phase followed by an IDLE data phase.
// Control flags back to the register bank are registered single-cycle pulses.
// Optional feature macro: DMAC_ERR_ABORT_EN.
// When it is defined, an m_HRESP port is added and an ERROR response aborts the channel.
module dmac_ch0_ctrl #(
  parameter int BUF_DEPTH = 16,
  parameter int BUF_AW    = 4   // must equal log2(BUF_DEPTH)
) (
  input  logic        r_HCLK,
  input  logic        r_HRESET,
  input  logic        CHANNEL_enable,
  input  logic [11:0] TS,
  input  logic [2:0]  BS,
  input  logic        DMACINTR_mask,
  input  logic [31:0] src_addr,
  input  logic [31:0] dest_addr,
  input  logic        m_HGRANT,
  input  logic        m_HREADY,
  input  logic [31:0] m_HRDATA,
`ifdef DMAC_ERR_ABORT_EN
  input  logic [1:0]  m_HRESP,
`endif
  output logic        m_HBUSREQ,
  output logic [1:0]  m_HTRANS,
  output logic        m_HWRITE,
  output logic [31:0] m_HADDR,
  output logic [31:0] m_HWDATA,
  output logic        load_DMAC_C0_Addr,
  output logic        src_addr_inc,
  output logic        dest_addr_inc,
  output logic        TransferSize_dec_flag,
  output logic        buffer_idx_inc,
  output logic        buffer_zero_flag,
  output logic        src_burst_zero_flag,
  output logic        dest_burst_zero_flag,
  output logic        CHANNEL_dis_flag,
  output logic        set_DMACINTR_status
);

  localparam logic [1:0]      HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]      HTRANS_NONSEQ = 2'b10;
  localparam logic [BUF_AW:0] CNT_ONE       = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [BUF_AW:0] cnt_q, cnt_d;
  logic [BUF_AW:0] beats_q, beats_d;

  logic load_q,   load_d;
  logic sinc_q,   sinc_d;
  logic dinc_q,   dinc_d;
  logic tsdec_q,  tsdec_d;
  logic bidx_q,   bidx_d;
  logic bzero_q,  bzero_d;
  logic sbz_q,    sbz_d;
  logic dbz_q,    dbz_d;
  logic chdis_q,  chdis_d;
  logic intr_q,   intr_d;

  logic [31:0] buf_q [BUF_DEPTH];
  logic        buf_we;

  logic [9:0]  words_now;
  logic [9:0]  words_eff;
  logic        en_eff;
  logic        last_beat;
  logic        err_resp;
  logic        unused_ts_lsb;

  // Burst length from the BS code, clipped to the buffer, then to the words left.
  function automatic logic [BUF_AW:0] calc_beats(input logic [2:0] bs,
                                                 input logic [9:0] words);
    logic [9:0]      blen;
    logic [BUF_AW:0] res;
    case (bs)
      3'd0:    blen = 10'd1;
      3'd1:    blen = 10'd4;
      3'd2:    blen = 10'd8;
      3'd3:    blen = 10'd16;
      default: blen = 10'd1;
    endcase
    if (blen > 10'(BUF_DEPTH)) blen = 10'(BUF_DEPTH);
    if (words < blen) res = words[BUF_AW:0];
    else              res = blen[BUF_AW:0];
    return res;
  endfunction

  // TS is a byte count in whole words; the two low bits carry no meaning.
  assign unused_ts_lsb = ^TS[1:0];
  assign words_now     = TS[11:2];

  // The decrement for the final write beat is still in flight during NEXT
  // (the bank acts on the pulse at the end of that cycle), so account for it here.
  assign words_eff = tsdec_q ? (words_now - 10'd1) : words_now;

  // The bank clears CHANNEL_enable one cycle after our disable pulse;
  // ignore the stale enable during that cycle so DONE is not re-entered.
  assign en_eff = CHANNEL_enable & ~chdis_q;

  assign last_beat = (cnt_q == (beats_q - CNT_ONE));

`ifdef DMAC_ERR_ABORT_EN
  assign err_resp = (m_HRESP == 2'b01);
`else
  assign err_resp = 1'b0;
`endif

  // Sequencer: next state, counters, flag pulses and the combinational bus drive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    load_d    = 1'b0;
    sinc_d    = 1'b0;
    dinc_d    = 1'b0;
    tsdec_d   = 1'b0;
    bidx_d    = 1'b0;
    bzero_d   = 1'b0;
    sbz_d     = 1'b0;
    dbz_d     = 1'b0;
    chdis_d   = 1'b0;
    intr_d    = 1'b0;
    buf_we    = 1'b0;
    m_HBUSREQ = 1'b0;
    m_HTRANS  = HTRANS_IDLE;
    m_HWRITE  = 1'b0;
    m_HADDR   = 32'd0;
    m_HWDATA  = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (en_eff) begin
          if (words_now != 10'd0) state_d = S_LOAD;
          else                    state_d = S_DONE;
        end
      end

      S_LOAD: begin
        load_d  = 1'b1;
        bzero_d = 1'b1;
        sbz_d   = 1'b1;
        dbz_d   = 1'b1;
        beats_d = calc_beats(BS, words_now);
        cnt_d   = '0;
        state_d = S_REQ;
      end

      S_REQ: begin
        m_HBUSREQ = 1'b1;
        if (m_HGRANT) state_d = S_RD_ADDR;
      end

      S_RD_ADDR: begin
        m_HBUSREQ = 1'b1;
        if (m_HGRANT) begin
          m_HTRANS = HTRANS_NONSEQ;
          m_HADDR  = src_addr;
          if (m_HREADY) begin
            sinc_d  = 1'b1;
            state_d = S_RD_DATA;
          end
        end
      end

      S_RD_DATA: begin
        m_HBUSREQ = 1'b1;
        if (m_HREADY) begin
          if (err_resp) begin
            state_d = S_ERR;
          end else begin
            buf_we = 1'b1;
            bidx_d = 1'b1;
            if (last_beat) begin
              cnt_d   = '0;
              bzero_d = 1'b1;
              state_d = S_WR_ADDR;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = S_RD_ADDR;
            end
          end
        end
      end

      S_WR_ADDR: begin
        m_HBUSREQ = 1'b1;
        if (m_HGRANT) begin
          m_HTRANS = HTRANS_NONSEQ;
          m_HWRITE = 1'b1;
          m_HADDR  = dest_addr;
          if (m_HREADY) begin
            dinc_d  = 1'b1;
            state_d = S_WR_DATA;
          end
        end
      end

      S_WR_DATA: begin
        m_HBUSREQ = 1'b1;
        m_HWDATA  = buf_q[cnt_q[BUF_AW-1:0]];
        if (m_HREADY) begin
          if (err_resp) begin
            state_d = S_ERR;
          end else begin
            tsdec_d = 1'b1;
            if (last_beat) begin
              sbz_d   = 1'b1;
              dbz_d   = 1'b1;
              state_d = S_NEXT;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = S_WR_ADDR;
            end
          end
        end
      end

      S_NEXT: begin
        if (!CHANNEL_enable) begin
          state_d = S_IDLE;
        end else if (words_eff == 10'd0) begin
          state_d = S_DONE;
        end else begin
          beats_d = calc_beats(BS, words_eff);
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end

      S_DONE: begin
        chdis_d = 1'b1;
        intr_d  = ~DMACINTR_mask;
        state_d = S_IDLE;
      end

      S_ERR: begin
        chdis_d = 1'b1;
        intr_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state and flag pulse registers; reset aborts straight to IDLE.
  always_ff @(posedge r_HCLK or posedge r_HRESET) begin
    if (r_HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      load_q  <= 1'b0;
      sinc_q  <= 1'b0;
      dinc_q  <= 1'b0;
      tsdec_q <= 1'b0;
      bidx_q  <= 1'b0;
      bzero_q <= 1'b0;
      sbz_q   <= 1'b0;
      dbz_q   <= 1'b0;
      chdis_q <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      load_q  <= load_d;
      sinc_q  <= sinc_d;
      dinc_q  <= dinc_d;
      tsdec_q <= tsdec_d;
      bidx_q  <= bidx_d;
      bzero_q <= bzero_d;
      sbz_q   <= sbz_d;
      dbz_q   <= dbz_d;
      chdis_q <= chdis_d;
      intr_q  <= intr_d;
    end
  end

  // Word buffer capture; contents are don't-care after reset.
  always_ff @(posedge r_HCLK) begin
    if (buf_we) buf_q[cnt_q[BUF_AW-1:0]] <= m_HRDATA;
  end

  assign load_DMAC_C0_Addr     = load_q;
  assign src_addr_inc          = sinc_q;
  assign dest_addr_inc         = dinc_q;
  assign TransferSize_dec_flag = tsdec_q;
  assign buffer_idx_inc        = bidx_q;
  assign buffer_zero_flag      = bzero_q;
  assign src_burst_zero_flag   = sbz_q;
  assign dest_burst_zero_flag  = dbz_q;
  assign CHANNEL_dis_flag      = chdis_q;
  assign set_DMACINTR_status   = intr_q;

endmodule

// File: tb/tb_dmac_ch0_ctrl.sv
// Testbench for dmac_ch0_ctrl: a table of whole-transfer vectors run against a
// small register-bank and bus-slave model, plus hand sequences for wait states,
// grant loss, mid-burst disable, asynchronous reset and (when built with
// DMAC_ERR_ABORT_EN) the error abort.
module tb_dmac_ch0_ctrl;

  logic        r_HCLK = 1'b0;
  logic        r_HRESET;
  logic        CHANNEL_enable;
  logic [11:0] TS;
  logic [2:0]  BS;
  logic        DMACINTR_mask;
  logic [31:0] src_addr;
  logic [31:0] dest_addr;
  logic        m_HGRANT;
  logic        m_HREADY;
  logic [31:0] m_HRDATA;
`ifdef DMAC_ERR_ABORT_EN
  logic [1:0]  m_HRESP;
`endif
  logic        m_HBUSREQ;
  logic [1:0]  m_HTRANS;
  logic        m_HWRITE;
  logic [31:0] m_HADDR;
  logic [31:0] m_HWDATA;
  logic        load_DMAC_C0_Addr;
  logic        src_addr_inc;
  logic        dest_addr_inc;
  logic        TransferSize_dec_flag;
  logic        buffer_idx_inc;
  logic        buffer_zero_flag;
  logic        src_burst_zero_flag;
  logic        dest_burst_zero_flag;
  logic        CHANNEL_dis_flag;
  logic        set_DMACINTR_status;

  always #5 r_HCLK = ~r_HCLK;

  dmac_ch0_ctrl #(.BUF_DEPTH(16), .BUF_AW(4)) dut (
    .r_HCLK                (r_HCLK),
    .r_HRESET              (r_HRESET),
    .CHANNEL_enable        (CHANNEL_enable),
    .TS                    (TS),
    .BS                    (BS),
    .DMACINTR_mask         (DMACINTR_mask),
    .src_addr              (src_addr),
    .dest_addr             (dest_addr),
    .m_HGRANT              (m_HGRANT),
    .m_HREADY              (m_HREADY),
    .m_HRDATA              (m_HRDATA),
`ifdef DMAC_ERR_ABORT_EN
    .m_HRESP               (m_HRESP),
`endif
    .m_HBUSREQ             (m_HBUSREQ),
    .m_HTRANS              (m_HTRANS),
    .m_HWRITE              (m_HWRITE),
    .m_HADDR               (m_HADDR),
    .m_HWDATA              (m_HWDATA),
    .load_DMAC_C0_Addr     (load_DMAC_C0_Addr),
    .src_addr_inc          (src_addr_inc),
    .dest_addr_inc         (dest_addr_inc),
    .TransferSize_dec_flag (TransferSize_dec_flag),
    .buffer_idx_inc        (buffer_idx_inc),
    .buffer_zero_flag      (buffer_zero_flag),
    .src_burst_zero_flag   (src_burst_zero_flag),
    .dest_burst_zero_flag  (dest_burst_zero_flag),
    .CHANNEL_dis_flag      (CHANNEL_dis_flag),
    .set_DMACINTR_status   (set_DMACINTR_status)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Register-bank programming and bench bookkeeping.
  logic [31:0] src0, dst0;
  int c_rd, c_wr, c_tsdec, c_dis, c_intr, c_rise, c_load;
  int c_bz, c_sbz, c_dbz, c_sinc, c_dinc, c_bidx, c_ungr, c_stall;
  int rd_addr_n, wr_addr_n, pend;
  logic [31:0] rq[$];
  logic        prev_busreq;
  int gl_cnt, st_cnt, gl_after, st_on_rd, err_on_wr;
  logic err_arm;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h3C3C_0F0F;
  endfunction

  function automatic logic [31:0] flags_vec();
    return {18'd0, m_HBUSREQ, m_HTRANS, m_HWRITE, load_DMAC_C0_Addr, src_addr_inc,
            dest_addr_inc, TransferSize_dec_flag, buffer_idx_inc, buffer_zero_flag,
            src_burst_zero_flag, dest_burst_zero_flag, CHANNEL_dis_flag, set_DMACINTR_status};
  endfunction

  // One clock cycle: drive slave inputs, observe the cycle, then apply bank updates.
  task automatic tick();
    logic f_load, f_sinc, f_dinc, f_tsdec, f_dis;
    logic rd_acc;
    logic [31:0] rd_a;
    logic [31:0] expd;
    m_HGRANT = (gl_cnt == 0);
    if (gl_cnt > 0) gl_cnt--;
    m_HREADY = (st_cnt == 0);
    if (st_cnt > 0) st_cnt--;
`ifdef DMAC_ERR_ABORT_EN
    m_HRESP = err_arm ? 2'b01 : 2'b00;
`endif
    err_arm = 1'b0;
    #1;
    if (!m_HGRANT) begin
      c_ungr++;
      chk("htrans_ungranted", 32'(m_HTRANS), 32'd0);
    end
    if (m_HBUSREQ && !prev_busreq) c_rise++;
    prev_busreq = m_HBUSREQ;
    rd_acc = 1'b0;
    rd_a   = 32'd0;
    if (pend != 0) begin
      if (!m_HREADY) begin
        c_stall++;
      end else begin
        if (pend == 1) begin
          rq.push_back(m_HRDATA);
          c_rd++;
        end else begin
          if (rq.size() == 0) begin
            chk("wdata_order", 32'd1, 32'd0);
          end else begin
            expd = rq.pop_front();
            chk("wdata", m_HWDATA, expd);
          end
          c_wr++;
          if (c_wr == gl_after) gl_cnt = 2;
        end
        pend = 0;
      end
    end else if (m_HTRANS == 2'b10 && m_HREADY) begin
      if (!m_HWRITE) begin
        chk("raddr", m_HADDR, src0 + 32'(4 * rd_addr_n));
        rd_addr_n++;
        pend   = 1;
        rd_acc = 1'b1;
        rd_a   = m_HADDR;
        if (rd_addr_n == st_on_rd) st_cnt = 3;
      end else begin
        chk("waddr", m_HADDR, dst0 + 32'(4 * wr_addr_n));
        wr_addr_n++;
        pend = 2;
        if (wr_addr_n == err_on_wr) err_arm = 1'b1;
      end
    end
    f_load  = load_DMAC_C0_Addr;
    f_sinc  = src_addr_inc;
    f_dinc  = dest_addr_inc;
    f_tsdec = TransferSize_dec_flag;
    f_dis   = CHANNEL_dis_flag;
    c_load  += int'(f_load);
    c_sinc  += int'(f_sinc);
    c_dinc  += int'(f_dinc);
    c_tsdec += int'(f_tsdec);
    c_dis   += int'(f_dis);
    c_intr  += int'(set_DMACINTR_status);
    c_bidx  += int'(buffer_idx_inc);
    c_bz    += int'(buffer_zero_flag);
    c_sbz   += int'(src_burst_zero_flag);
    c_dbz   += int'(dest_burst_zero_flag);
    @(posedge r_HCLK);
    #1;
    if (f_load) begin
      src_addr  = src0;
      dest_addr = dst0;
    end
    if (f_sinc)  src_addr  = src_addr + 32'd4;
    if (f_dinc)  dest_addr = dest_addr + 32'd4;
    if (f_tsdec) TS = TS - 12'd4;
    if (f_dis)   CHANNEL_enable = 1'b0;
    if (rd_acc)  m_HRDATA = pat(rd_a);
  endtask

  task automatic clear_counts();
    c_rd = 0; c_wr = 0; c_tsdec = 0; c_dis = 0; c_intr = 0; c_rise = 0; c_load = 0;
    c_bz = 0; c_sbz = 0; c_dbz = 0; c_sinc = 0; c_dinc = 0; c_bidx = 0;
    c_ungr = 0; c_stall = 0; rd_addr_n = 0; wr_addr_n = 0; pend = 0;
    rq.delete();
  endtask

  task automatic start_run(input logic [11:0] ts, input logic [2:0] bs, input logic mask,
                           input logic [31:0] s, input logic [31:0] d);
    clear_counts();
    src0 = s;
    dst0 = d;
    TS = ts;
    BS = bs;
    DMACINTR_mask = mask;
    CHANNEL_enable = 1'b1;
  endtask

  task automatic run_to_end();
    int n;
    n = 0;
    while (CHANNEL_enable && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("run_timeout", 32'd1, 32'd0);
    repeat (5) tick();
  endtask

  typedef struct {
    logic [11:0] ts;
    logic [2:0]  bs;
    logic        mask;
    logic [31:0] s;
    logic [31:0] d;
    int          e_beats;
    int          e_rise;
    int          e_bz;
    int          e_intr;
    int          e_load;
    logic [11:0] e_fts;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{12'd16, 3'd1, 1'b0, 32'h1000, 32'h2000,  4, 1, 2, 1, 1, 12'd0};
    vecs[1] = '{12'd24, 3'd1, 1'b1, 32'h3000, 32'h4000,  6, 2, 3, 0, 1, 12'd0};
    vecs[2] = '{12'd12, 3'd0, 1'b0, 32'h0100, 32'h0800,  3, 3, 4, 1, 1, 12'd0};
    vecs[3] = '{12'd64, 3'd3, 1'b0, 32'hA000, 32'hB000, 16, 1, 2, 1, 1, 12'd0};
    vecs[4] = '{12'd40, 3'd2, 1'b1, 32'hC000, 32'hD000, 10, 2, 3, 0, 1, 12'd0};
    vecs[5] = '{12'd8,  3'd5, 1'b0, 32'h0040, 32'h0080,  2, 2, 3, 1, 1, 12'd0};
    vecs[6] = '{12'd18, 3'd1, 1'b0, 32'h7000, 32'h7800,  4, 1, 2, 1, 1, 12'd2};
    vecs[7] = '{12'd0,  3'd1, 1'b0, 32'hE000, 32'hF000,  0, 0, 0, 1, 0, 12'd0};

    r_HRESET = 1'b1;
    CHANNEL_enable = 1'b0;
    TS = 12'd0; BS = 3'd0; DMACINTR_mask = 1'b0;
    src_addr = 32'd0; dest_addr = 32'd0;
    m_HGRANT = 1'b1; m_HREADY = 1'b1; m_HRDATA = 32'd0;
`ifdef DMAC_ERR_ABORT_EN
    m_HRESP = 2'b00;
`endif
    src0 = 32'd0; dst0 = 32'd0;
    prev_busreq = 1'b0;
    gl_cnt = 0; st_cnt = 0; gl_after = 0; st_on_rd = 0; err_on_wr = 0; err_arm = 1'b0;
    clear_counts();

    #1;
    chk("reset_ctrl_outputs", flags_vec(), 32'd0);
    chk("reset_haddr", m_HADDR, 32'd0);
    chk("reset_hwdata", m_HWDATA, 32'd0);
    repeat (2) @(posedge r_HCLK);
    #1;
    r_HRESET = 1'b0;

    // Whole transfers with grant and ready always high.
    for (int i = 0; i < 8; i++) begin
      start_run(vecs[i].ts, vecs[i].bs, vecs[i].mask, vecs[i].s, vecs[i].d);
      run_to_end();
      chk($sformatf("v%0d_reads", i),   32'(c_rd),    32'(vecs[i].e_beats));
      chk($sformatf("v%0d_writes", i),  32'(c_wr),    32'(vecs[i].e_beats));
      chk($sformatf("v%0d_tsdec", i),   32'(c_tsdec), 32'(vecs[i].e_beats));
      chk($sformatf("v%0d_srcinc", i),  32'(c_sinc),  32'(vecs[i].e_beats));
      chk($sformatf("v%0d_dstinc", i),  32'(c_dinc),  32'(vecs[i].e_beats));
      chk($sformatf("v%0d_bufidx", i),  32'(c_bidx),  32'(vecs[i].e_beats));
      chk($sformatf("v%0d_busreq_rises", i), 32'(c_rise), 32'(vecs[i].e_rise));
      chk($sformatf("v%0d_load", i),    32'(c_load),  32'(vecs[i].e_load));
      chk($sformatf("v%0d_bufzero", i), 32'(c_bz),    32'(vecs[i].e_bz));
      chk($sformatf("v%0d_srcbz", i),   32'(c_sbz),   32'(vecs[i].e_bz));
      chk($sformatf("v%0d_dstbz", i),   32'(c_dbz),   32'(vecs[i].e_bz));
      chk($sformatf("v%0d_chdis", i),   32'(c_dis),   32'd1);
      chk($sformatf("v%0d_intr", i),    32'(c_intr),  32'(vecs[i].e_intr));
      chk($sformatf("v%0d_final_ts", i), 32'(TS),     32'(vecs[i].e_fts));
      chk($sformatf("v%0d_busreq_end", i), 32'(m_HBUSREQ), 32'd0);
    end

    // Wait states on read beat 2 and a 2-cycle grant loss in WR_ADDR.
    st_on_rd = 2;
    gl_after = 1;
    start_run(12'd16, 3'd1, 1'b0, 32'h5000, 32'h6000);
    run_to_end();
    st_on_rd = 0;
    gl_after = 0;
    chk("ws_reads",    32'(c_rd),    32'd4);
    chk("ws_writes",   32'(c_wr),    32'd4);
    chk("ws_tsdec",    32'(c_tsdec), 32'd4);
    chk("ws_srcinc",   32'(c_sinc),  32'd4);
    chk("ws_dstinc",   32'(c_dinc),  32'd4);
    chk("ws_stall_cycles",  32'(c_stall), 32'd3);
    chk("ws_ungrant_cycles", 32'(c_ungr), 32'd2);
    chk("ws_chdis",    32'(c_dis),   32'd1);
    chk("ws_intr",     32'(c_intr),  32'd1);
    chk("ws_rises",    32'(c_rise),  32'd1);

    // Channel disabled mid-burst: the burst completes, then IDLE without interrupt.
    begin
      int n;
      start_run(12'd32, 3'd1, 1'b0, 32'h1100, 32'h2200);
      n = 0;
      while (c_rd < 2 && n < 500) begin
        tick();
        n++;
      end
      if (n >= 500) chk("dis_timeout", 32'd1, 32'd0);
      CHANNEL_enable = 1'b0;
      repeat (60) tick();
      chk("dis_reads",  32'(c_rd),    32'd4);
      chk("dis_writes", 32'(c_wr),    32'd4);
      chk("dis_tsdec",  32'(c_tsdec), 32'd4);
      chk("dis_chdis",  32'(c_dis),   32'd0);
      chk("dis_intr",   32'(c_intr),  32'd0);
      chk("dis_rises",  32'(c_rise),  32'd1);
      chk("dis_ts_left", 32'(TS),     32'd16);
      chk("dis_busreq_end", 32'(m_HBUSREQ), 32'd0);
    end

    // Asynchronous reset during a write data phase.
    begin
      int n;
      start_run(12'd16, 3'd1, 1'b0, 32'h8000, 32'h9000);
      n = 0;
      while (pend != 2 && n < 500) begin
        tick();
        n++;
      end
      if (n >= 500) chk("rst_timeout", 32'd1, 32'd0);
      #2;
      r_HRESET = 1'b1;
      #1;
      chk("rst_mid_outputs", flags_vec(), 32'd0);
      chk("rst_mid_hwdata", m_HWDATA, 32'd0);
      repeat (2) @(posedge r_HCLK);
      #1;
      r_HRESET = 1'b0;
      CHANNEL_enable = 1'b0;
      TS = 12'd0;
      clear_counts();
      repeat (10) tick();
      chk("rst_idle_rises", 32'(c_rise), 32'd0);
      chk("rst_idle_load",  32'(c_load), 32'd0);
      chk("rst_idle_chdis", 32'(c_dis),  32'd0);
      chk("rst_idle_busreq", 32'(m_HBUSREQ), 32'd0);
      start_run(12'd8, 3'd1, 1'b0, 32'h8800, 32'h9800);
      run_to_end();
      chk("rst_after_reads", 32'(c_rd),  32'd2);
      chk("rst_after_writes", 32'(c_wr), 32'd2);
      chk("rst_after_chdis", 32'(c_dis), 32'd1);
    end

`ifdef DMAC_ERR_ABORT_EN
    // ERROR response on write beat 3 of a 4-beat burst, interrupt masked.
    err_on_wr = 3;
    start_run(12'd16, 3'd1, 1'b1, 32'h4400, 32'h5500);
    run_to_end();
    err_on_wr = 0;
    chk("err_reads",  32'(c_rd),    32'd4);
    chk("err_tsdec",  32'(c_tsdec), 32'd2);
    chk("err_chdis",  32'(c_dis),   32'd1);
    chk("err_intr",   32'(c_intr),  32'd1);
    chk("err_ts_left", 32'(TS),     32'd8);
    chk("err_busreq_end", 32'(m_HBUSREQ), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
